// File: rtl/jstk_pkg.sv
// Shared constants and types for the JSTK2 LED mapper.
package jstk_pkg;

  // LED numbering as printed on the ICEStick
  localparam int unsigned LED_XLO = 1;
  localparam int unsigned LED_YLO = 2;
  localparam int unsigned LED_XHI = 3;
  localparam int unsigned LED_YHI = 4;
  localparam int unsigned LED_BTN = 5;
  localparam int unsigned N_LED   = 5;

  // Default axis thresholds for a 10-bit joystick position
  localparam int unsigned DEF_LO_TH = 400;
  localparam int unsigned DEF_HI_TH = 600;
  localparam int unsigned DEF_HYST  = 16;

  // Hysteretic direction flags of one axis
  typedef struct packed {
    logic lo;
    logic hi;
  } dir_flags_t;

  // Width of a counter that must hold 0..max_val (at least one bit)
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/jstk_led_mapper_if.sv
// Decoded joystick sample bus from the JSTK2 SPI decoder.
interface jstk_led_mapper_if #(
  parameter int unsigned POS_W = 10,
  parameter int unsigned N_BTN = 2
) ();

  logic             sample_valid;
  logic [POS_W-1:0] xpos;
  logic [POS_W-1:0] ypos;
  logic [N_BTN-1:0] button;

  modport master (output sample_valid, output xpos, output ypos, output button);
  modport slave  (input  sample_valid, input  xpos, input  ypos, input  button);

endinterface

// File: rtl/jstk_axis_dir.sv
// One joystick axis: position capture, hysteretic lo/hi flags and PWM duty.
module jstk_axis_dir import jstk_pkg::*; #(
  parameter int unsigned POS_W    = 10,
  parameter int unsigned LO_TH    = DEF_LO_TH,
  parameter int unsigned HI_TH    = DEF_HI_TH,
  parameter int unsigned HYST     = DEF_HYST,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned MIN_DUTY = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic [POS_W-1:0] pos_in,
  input  logic             upd,
  input  logic             clr,
  output dir_flags_t       flags_o,
  output logic [PWM_W-1:0] duty_o
);

  localparam logic [POS_W-1:0] LO_P   = POS_W'(LO_TH);
  localparam logic [POS_W-1:0] HI_P   = POS_W'(HI_TH);
  localparam logic [POS_W-1:0] LO_CLR = POS_W'(LO_TH + HYST);
  localparam logic [POS_W-1:0] HI_CLR = POS_W'(HI_TH - HYST);
  localparam logic [POS_W-1:0] SAT_P  = POS_W'((1 << PWM_W) - 1);
  localparam logic [PWM_W-1:0] SAT_D  = '1;
  localparam logic [PWM_W-1:0] MIN_D  = PWM_W'(MIN_DUTY);

  logic [POS_W-1:0] pos_q, pos_d;
  dir_flags_t       flags_q, flags_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [POS_W-1:0] depth;

  // Capture on strobe; flags and duty follow one cycle later from the captured value
  always_comb begin
    pos_d   = cap_en ? pos_in : pos_q;
    flags_d = flags_q;
    duty_d  = duty_q;
    depth   = '0;
    if (clr) begin
      flags_d = '0;
      duty_d  = '0;
    end else if (upd) begin
      if (pos_q < LO_P)        flags_d.lo = 1'b1;
      else if (pos_q >= LO_CLR) flags_d.lo = 1'b0;
      if (pos_q > HI_P)        flags_d.hi = 1'b1;
      else if (pos_q <= HI_CLR) flags_d.hi = 1'b0;

      // Depth is zero while the flag is only held by hysteresis
      if (flags_d.lo)      depth = (pos_q < LO_P) ? (LO_P - pos_q) : '0;
      else if (flags_d.hi) depth = (pos_q > HI_P) ? (pos_q - HI_P) : '0;

      if (!flags_d.lo && !flags_d.hi) duty_d = '0;
      else if (depth == '0)           duty_d = MIN_D;
      else if (depth > SAT_P)         duty_d = SAT_D;
      else                            duty_d = PWM_W'(depth);
    end
  end

  // Axis state registers; reset parks the position in the neutral zone
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q   <= LO_CLR;
      flags_q <= '0;
      duty_q  <= '0;
    end else begin
      pos_q   <= pos_d;
      flags_q <= flags_d;
      duty_q  <= duty_d;
    end
  end

  assign flags_o = flags_q;
  assign duty_o  = duty_q;

endmodule

// File: rtl/jstk_led_mapper.sv
// Maps decoded JSTK2 joystick samples onto the five ICEStick LEDs.
module jstk_led_mapper import jstk_pkg::*; #(
  parameter int unsigned POS_W       = 10,
  parameter int unsigned LO_TH       = DEF_LO_TH,
  parameter int unsigned HI_TH       = DEF_HI_TH,
  parameter int unsigned HYST        = DEF_HYST,
  parameter int unsigned PWM_W       = 8,
  parameter int unsigned MIN_DUTY    = 32,
  parameter int unsigned N_BTN       = 2,
  parameter int unsigned STRETCH_CYC = 1200000,
  parameter int unsigned TIMEOUT_CYC = 2400000
) (
  input  logic               clk,
  input  logic               rst,
  jstk_led_mapper_if.slave   smp,
  output logic               LED1,
  output logic               LED2,
  output logic               LED3,
  output logic               LED4,
  output logic               LED5,
  output logic               stale
);

  localparam int unsigned      TW        = cnt_w(TIMEOUT_CYC);
  localparam int unsigned      SW        = cnt_w(STRETCH_CYC);
  localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]    TO_MAX    = TW'(TIMEOUT_CYC);
  localparam logic [SW-1:0]    HOLD_LOAD = SW'(STRETCH_CYC);
  localparam logic [PWM_W-1:0] DUTY_FULL = '1;

  logic [N_BTN-1:0] btn_q, btn_d;
  logic             cap_v_q, cap_v_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic             stale_q, stale_d;
  logic             press_q, press_d;
  logic [SW-1:0]    hold_q, hold_d;
  logic [N_LED:1]   led_q, led_d;
  logic             expire;

  dir_flags_t       x_flags, y_flags;
  logic [PWM_W-1:0] x_duty, y_duty;

  // PWM compare; a saturated duty drives the LED solid
  function automatic logic pwm_on(input logic flag, input logic [PWM_W-1:0] duty,
                                  input logic [PWM_W-1:0] cnt);
    return flag && ((duty == DUTY_FULL) || (cnt < duty));
  endfunction

  jstk_axis_dir #(
    .POS_W(POS_W), .LO_TH(LO_TH), .HI_TH(HI_TH), .HYST(HYST),
    .PWM_W(PWM_W), .MIN_DUTY(MIN_DUTY)
  ) u_axis_x (
    .clk(clk), .rst(rst), .cap_en(smp.sample_valid), .pos_in(smp.xpos),
    .upd(cap_v_q), .clr(expire), .flags_o(x_flags), .duty_o(x_duty)
  );

  jstk_axis_dir #(
    .POS_W(POS_W), .LO_TH(LO_TH), .HI_TH(HI_TH), .HYST(HYST),
    .PWM_W(PWM_W), .MIN_DUTY(MIN_DUTY)
  ) u_axis_y (
    .clk(clk), .rst(rst), .cap_en(smp.sample_valid), .pos_in(smp.ypos),
    .upd(cap_v_q), .clr(expire), .flags_o(y_flags), .duty_o(y_duty)
  );

  // Capture, PWM, timeout, button stretch and LED next-state
  always_comb begin
    btn_d     = smp.sample_valid ? smp.button : btn_q;
    cap_v_d   = smp.sample_valid;
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);

    // A strobe in the expiry cycle wins, so expiry needs an idle input
    expire    = !smp.sample_valid && (to_cnt_q == TO_LAST);
    if (smp.sample_valid)      to_cnt_d = '0;
    else if (to_cnt_q == TO_MAX) to_cnt_d = to_cnt_q;
    else                       to_cnt_d = to_cnt_q + TW'(1);

    stale_d = stale_q;
    press_d = press_q;
    if (cap_v_q) begin
      stale_d = 1'b0;
      press_d = |btn_q;
    end
    if (expire) begin
      stale_d = 1'b1;
      press_d = 1'b0;
    end

    // Reload while pressed; count down only after release
    if (expire)              hold_d = '0;
    else if (press_q)        hold_d = HOLD_LOAD;
    else if (hold_q != '0)   hold_d = hold_q - SW'(1);
    else                     hold_d = hold_q;

    led_d          = '0;
    led_d[LED_XLO] = pwm_on(x_flags.lo, x_duty, pwm_cnt_q);
    led_d[LED_XHI] = pwm_on(x_flags.hi, x_duty, pwm_cnt_q);
    led_d[LED_YLO] = pwm_on(y_flags.lo, y_duty, pwm_cnt_q);
    led_d[LED_YHI] = pwm_on(y_flags.hi, y_duty, pwm_cnt_q);
    led_d[LED_BTN] = press_q || (hold_q != '0);
    if (expire) led_d = '0;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q     <= '0;
      cap_v_q   <= 1'b0;
      pwm_cnt_q <= '0;
      to_cnt_q  <= '0;
      stale_q   <= 1'b1;
      press_q   <= 1'b0;
      hold_q    <= '0;
      led_q     <= '0;
    end else begin
      btn_q     <= btn_d;
      cap_v_q   <= cap_v_d;
      pwm_cnt_q <= pwm_cnt_d;
      to_cnt_q  <= to_cnt_d;
      stale_q   <= stale_d;
      press_q   <= press_d;
      hold_q    <= hold_d;
      led_q     <= led_d;
    end
  end

  assign LED1  = led_q[LED_XLO];
  assign LED2  = led_q[LED_YLO];
  assign LED3  = led_q[LED_XHI];
  assign LED4  = led_q[LED_YHI];
  assign LED5  = led_q[LED_BTN];
  assign stale = stale_q;

endmodule
